// File: rtl/note_display_pkg.sv
// note_display_pkg
// Shared definitions for the seven-segment note display.
//   - Active-low glyph constants in {g,f,e,d,c,b,a} order.
//   - dig_t: 2-bit digit index, where 0 is the rightmost digit.
//   - note_glyph():   maps note_switches {C,D,E,F,G,A,B} to the glyph of its
//                     highest-priority set bit, or a dash when no bit is set.
//   - octave_glyph(): maps a 3-bit octave to its numeral glyph.
package note_display_pkg;

    typedef logic [1:0] dig_t;

    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_B     = 7'b0000011;
    localparam logic [6:0] GLYPH_C     = 7'b1000110;
    localparam logic [6:0] GLYPH_D     = 7'b0100001;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_F     = 7'b0001110;
    localparam logic [6:0] GLYPH_G     = 7'b1000010;
    localparam logic [6:0] GLYPH_P     = 7'b0001100;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;

    // Bit 6 (C) has the highest priority and bit 0 (B) the lowest.
    function automatic logic [6:0] note_glyph(input logic [6:0] sw);
        logic [6:0] g;
        casez (sw)
            7'b1??????: g = GLYPH_C;
            7'b01?????: g = GLYPH_D;
            7'b001????: g = GLYPH_E;
            7'b0001???: g = GLYPH_F;
            7'b00001??: g = GLYPH_G;
            7'b000001?: g = GLYPH_A;
            7'b0000001: g = GLYPH_B;
            default:    g = GLYPH_DASH;
        endcase
        return g;
    endfunction

    function automatic logic [6:0] octave_glyph(input logic [2:0] oct);
        logic [6:0] g;
        case (oct)
            3'd0:    g = GLYPH_0;
            3'd1:    g = GLYPH_1;
            3'd2:    g = GLYPH_2;
            3'd3:    g = GLYPH_3;
            3'd4:    g = GLYPH_4;
            3'd5:    g = GLYPH_5;
            3'd6:    g = GLYPH_6;
            default: g = GLYPH_7;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/note_display_if.sv
// note_display_if
// Groups the control-state inputs and the display pins of note_display.
//   note_switches[6:0]  {C,D,E,F,G,A,B}
//   octave[2:0]         current octave, 0-7
//   playback_active     playback mode flag
//   an[3:0]             anode enables, active-low; an[0] is the rightmost digit
//   seg[6:0]            cathodes, active-low, {g,f,e,d,c,b,a}
//   dp                  decimal point, active-low
// slave:  the display block, which consumes the state and drives the pins.
// master: the control side, which drives the state and observes the pins.
interface note_display_if;
    logic [6:0] note_switches;
    logic [2:0] octave;
    logic       playback_active;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport slave (
        input  note_switches, octave, playback_active,
        output an, seg, dp
    );

    modport master (
        output note_switches, octave, playback_active,
        input  an, seg, dp
    );
endinterface

// File: rtl/note_display.sv
// note_display
// Drives a 4-digit common-anode seven-segment display with the current note,
// the octave and a blinking playback marker. The digits are scanned 0,1,2,3.
// Inputs are captured once per full scan, so a digit never shows a mix of old
// and new state. Each digit slot begins with a short period in which all
// anodes are off, which suppresses ghosting.
// Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset
//   dif  note_display_if.slave: state inputs and the an/seg/dp outputs
// Digit map: dig3 shows the note letter (a dash when no note is set), dig2
// shows the octave, dig1 is blank, and dig0 shows a blinking P during playback.
module note_display
    import note_display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2000,
    parameter int BLINK_DIV    = 50000000
) (
    input  logic           clk,
    input  logic           rst,
    note_display_if.slave  dif
);

    localparam int RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [RC_W-1:0] RC_MAX    = RC_W'(REFRESH_DIV - 1);
    localparam logic [RC_W-1:0] BLANK_END = RC_W'(BLANK_CYCLES);
    localparam logic [BC_W-1:0] BC_MAX    = BC_W'(BLINK_DIV - 1);

    logic [RC_W-1:0] rc_q, rc_d;
    dig_t            dig_q, dig_d;
    logic [BC_W-1:0] bc_q, bc_d;
    logic            blink_q, blink_d;

    // Snapshot registers. The displayed content comes only from these.
    logic [6:0]      note_q, note_d;
    logic [2:0]      oct_q, oct_d;
    logic            pb_q, pb_d;

    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;

    logic            rc_wrap, bc_wrap;
    logic [6:0]      glyph;

    always_comb begin
        rc_wrap = (rc_q == RC_MAX);
        bc_wrap = (bc_q == BC_MAX);

        rc_d    = rc_wrap ? '0 : rc_q + 1'b1;
        dig_d   = rc_wrap ? dig_q + 2'd1 : dig_q;

        // The blink counter runs freely and is independent of the scan.
        bc_d    = bc_wrap ? '0 : bc_q + 1'b1;
        blink_d = blink_q ^ bc_wrap;

        // Capture on the last cycle of dig3, so the new content appears at
        // the start of dig0.
        note_d  = note_q;
        oct_d   = oct_q;
        pb_d    = pb_q;
        if (rc_wrap && dig_q == 2'd3) begin
            note_d = note_glyph(dif.note_switches);
            oct_d  = dif.octave;
            pb_d   = dif.playback_active;
        end

        case (dig_q)
            2'd3:    glyph = note_q;
            2'd2:    glyph = octave_glyph(oct_q);
            2'd1:    glyph = GLYPH_BLANK;
            default: glyph = (pb_q && !blink_q) ? GLYPH_P : GLYPH_BLANK;
        endcase

        if (rc_q < BLANK_END) begin
            an_d  = 4'b1111;
            seg_d = GLYPH_BLANK;
        end else begin
            an_d  = ~(4'b0001 << dig_q);
            seg_d = glyph;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rc_q    <= '0;
            dig_q   <= '0;
            bc_q    <= '0;
            blink_q <= 1'b0;
            note_q  <= GLYPH_DASH;
            oct_q   <= 3'd0;
            pb_q    <= 1'b0;
            an_q    <= 4'b1111;
            seg_q   <= GLYPH_BLANK;
        end else begin
            rc_q    <= rc_d;
            dig_q   <= dig_d;
            bc_q    <= bc_d;
            blink_q <= blink_d;
            note_q  <= note_d;
            oct_q   <= oct_d;
            pb_q    <= pb_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign dif.an  = an_q;
    assign dif.seg = seg_q;
    assign dif.dp  = 1'b1;

endmodule
